// File: rtl/mipi_frame_sequencer.sv
// CSI-2 capture sequencer: resets the RX chain, waits for lock, skips partial frames, counts whole frames and checks geometry.
// Optional watchdog on LOCK/SYNC/GAP is compiled in with FRAME_SEQ_TIMEOUT_EN.
module mipi_frame_sequencer #(
  parameter int PIX_CNT_W   = 12,
  parameter int LINE_CNT_W  = 12,
  parameter int FRAME_CNT_W = 8,
  parameter int RST_HOLD    = 16,
  parameter int TIMEOUT     = 2**20
) (
  input  logic                   clk_pixel_i,
  input  logic                   reset_i,
  input  logic                   pll_lock_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [FRAME_CNT_W-1:0] num_frames_i,
  input  logic [PIX_CNT_W-1:0]   exp_pix_i,
  input  logic [LINE_CNT_W-1:0]  exp_lines_i,
  input  logic                   fv_i,
  input  logic                   lv_i,
  output logic                   rx_reset_n_o,
  output logic                   capture_en_o,
  output logic                   sof_o,
  output logic                   eof_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic [3:0]             err_flags_o
);
  localparam int RC_W = $clog2(RST_HOLD + 1);

  typedef enum logic [2:0] {S_IDLE, S_RST, S_LOCK, S_SYNC, S_CAPT, S_GAP, S_DONE} state_t;
  state_t state_q, state_d;

  logic fv_q, fv_prev_q, lv_q, lv_prev_q;
  logic seen_low_q, seen_low_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [FRAME_CNT_W-1:0] num_q, num_d, frame_q, frame_d, frame_inc;
  logic [PIX_CNT_W-1:0] exp_pix_q, exp_pix_d, pix_q, pix_d, pix_tot;
  logic [LINE_CNT_W-1:0] exp_lines_q, exp_lines_d, line_q, line_d, line_tot;
  logic [3:0] err_q, err_d;
  logic sof_q, sof_d, eof_q, eof_d, done_q, done_d, busy_q, cap_q, rxn_q;
  logic fv_rise, fv_fall, line_end, live, wd_hit;

  assign fv_rise   = fv_q & ~fv_prev_q;
  assign fv_fall   = ~fv_q & fv_prev_q;
  // A line also ends when the frame closes while lv is still high.
  assign line_end  = (~lv_q & lv_prev_q) | (fv_fall & lv_q);
  assign pix_tot   = (lv_q && pix_q != '1) ? pix_q + 1'b1 : pix_q;
  assign line_tot  = (line_end && line_q != '1) ? line_q + 1'b1 : line_q;
  assign frame_inc = frame_q + 1'b1;
  assign live      = (state_q == S_SYNC) || (state_q == S_CAPT) || (state_q == S_GAP);

`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic wd_state;
  assign wd_state = (state_q == S_LOCK) || (state_q == S_SYNC) || (state_q == S_GAP);
  assign wd_hit   = wd_state && (wd_q == WD_W'(TIMEOUT - 1));
  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) wd_d = '0;
    else if (wd_state)      wd_d = wd_q + 1'b1;
  end
  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    seen_low_d  = seen_low_q;
    num_d       = num_q;
    exp_pix_d   = exp_pix_q;
    exp_lines_d = exp_lines_q;
    pix_d       = pix_q;
    line_d      = line_q;
    frame_d     = frame_q;
    err_d       = err_q;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: if (start_i && !abort_i) begin
        num_d       = num_frames_i;
        exp_pix_d   = exp_pix_i;
        exp_lines_d = exp_lines_i;
        err_d       = '0;
        frame_d     = '0;
        rst_cnt_d   = '0;
        state_d     = S_RST;
      end
      S_RST: begin
        if (rst_cnt_q == RC_W'(RST_HOLD - 1)) state_d = S_LOCK;
        else                                  rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_LOCK: if (pll_lock_i) begin
        seen_low_d = 1'b0;
        state_d    = S_SYNC;
      end
      S_SYNC: begin
        // Only a rise preceded by fv low inside SYNC starts a whole frame.
        if (!fv_q) seen_low_d = 1'b1;
        if (fv_rise && seen_low_q) begin
          sof_d   = 1'b1;
          pix_d   = '0;
          line_d  = '0;
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        pix_d = pix_tot;
        if (line_end) begin
          if (pix_tot != exp_pix_q) err_d[0] = 1'b1;
          line_d = line_tot;
          pix_d  = '0;
        end
        if (fv_fall) begin
          if (line_tot != exp_lines_q) err_d[1] = 1'b1;
          eof_d   = 1'b1;
          frame_d = frame_inc;
          line_d  = '0;
          pix_d   = '0;
          state_d = (num_q != '0 && frame_inc == num_q) ? S_DONE : S_GAP;
        end
      end
      S_GAP: if (fv_rise) begin
        sof_d   = 1'b1;
        pix_d   = '0;
        line_d  = '0;
        state_d = S_CAPT;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (live && !pll_lock_i) begin
      err_d[2] = 1'b1;
      done_d   = 1'b1;
      sof_d    = 1'b0;
      eof_d    = 1'b0;
      frame_d  = frame_q;
      state_d  = S_IDLE;
    end
    if (wd_hit) begin
      err_d[3] = 1'b1;
      done_d   = 1'b1;
      state_d  = S_IDLE;
    end
    if (abort_i) begin
      err_d   = err_q;
      frame_d = frame_q;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      done_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk_pixel_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      fv_q        <= 1'b0;
      fv_prev_q   <= 1'b0;
      lv_q        <= 1'b0;
      lv_prev_q   <= 1'b0;
      seen_low_q  <= 1'b0;
      rst_cnt_q   <= '0;
      num_q       <= '0;
      exp_pix_q   <= '0;
      exp_lines_q <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      frame_q     <= '0;
      err_q       <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cap_q       <= 1'b0;
      rxn_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      fv_q        <= fv_i;
      fv_prev_q   <= fv_q;
      lv_q        <= lv_i;
      lv_prev_q   <= lv_q;
      seen_low_q  <= seen_low_d;
      rst_cnt_q   <= rst_cnt_d;
      num_q       <= num_d;
      exp_pix_q   <= exp_pix_d;
      exp_lines_q <= exp_lines_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      done_q      <= done_d;
      busy_q      <= (state_d != S_IDLE);
      cap_q       <= (state_d == S_CAPT) && lv_i;
      rxn_q       <= (state_d != S_RST);
    end
  end

  assign rx_reset_n_o = rxn_q;
  assign capture_en_o = cap_q;
  assign sof_o        = sof_q;
  assign eof_o        = eof_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign frame_cnt_o  = frame_q;
  assign err_flags_o  = err_q;
endmodule

// File: tb/tb_mipi_frame_sequencer.sv
// Randomized self-checking bench for mipi_frame_sequencer with a frame-level reference model.
module tb_mipi_frame_sequencer;
  logic clk_pixel_i = 1'b0, reset_i = 1'b1, pll_lock_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
  logic [7:0] num_frames_i = '0;
  logic [11:0] exp_pix_i = '0, exp_lines_i = '0;
  logic fv_i = 1'b0, lv_i = 1'b0;
  logic rx_reset_n_o, capture_en_o, sof_o, eof_o, busy_o, done_o;
  logic [7:0] frame_cnt_o;
  logic [3:0] err_flags_o;

  mipi_frame_sequencer #(.TIMEOUT(100)) dut (
    .clk_pixel_i(clk_pixel_i), .reset_i(reset_i), .pll_lock_i(pll_lock_i),
    .start_i(start_i), .abort_i(abort_i), .num_frames_i(num_frames_i),
    .exp_pix_i(exp_pix_i), .exp_lines_i(exp_lines_i), .fv_i(fv_i), .lv_i(lv_i),
    .rx_reset_n_o(rx_reset_n_o), .capture_en_o(capture_en_o), .sof_o(sof_o),
    .eof_o(eof_o), .busy_o(busy_o), .done_o(done_o), .frame_cnt_o(frame_cnt_o),
    .err_flags_o(err_flags_o));

  always #5 clk_pixel_i = ~clk_pixel_i;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, n_sof = 0, n_eof = 0, n_done = 0, n_cap = 0, n_rstlow = 0, n_wrap = 0;
  int last_eof_cyc = 0, last_done_cyc = 0, rst_fall_cyc = 0, start_cyc = 0;
  logic rstn_prev = 1'b1;
  logic [7:0] fc_prev = '0;

  // Event counters sampled on the falling edge, well away from DUT updates.
  always @(negedge clk_pixel_i) begin
    cyc <= cyc + 1;
    if (sof_o) n_sof <= n_sof + 1;
    if (eof_o) begin n_eof <= n_eof + 1; last_eof_cyc <= cyc; end
    if (done_o) begin n_done <= n_done + 1; last_done_cyc <= cyc; end
    if (capture_en_o) n_cap <= n_cap + 1;
    if (!rx_reset_n_o) n_rstlow <= n_rstlow + 1;
    if (!rx_reset_n_o && rstn_prev) rst_fall_cyc <= cyc;
    if (start_i) start_cyc <= cyc;
    if (fc_prev == 8'd255 && frame_cnt_o == 8'd0) n_wrap <= n_wrap + 1;
    rstn_prev <= rx_reset_n_o;
    fc_prev <= frame_cnt_o;
  end

  // Reference model state: expected flags and captured pixels for the current run.
  int m_exp_pix, m_exp_lines, m_err, m_pix;
  int b_sof, b_eof, b_done, b_cap, b_rst, b_wrap;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pixel_i);
    #1;
  endtask

  task automatic snap();
    b_sof = n_sof; b_eof = n_eof; b_done = n_done; b_cap = n_cap; b_rst = n_rstlow; b_wrap = n_wrap;
  endtask

  task automatic do_start(input int num, input int ep, input int el);
    num_frames_i = 8'(num); exp_pix_i = 12'(ep); exp_lines_i = 12'(el);
    m_exp_pix = ep; m_exp_lines = el; m_err = 0; m_pix = 0;
    snap();
    start_i = 1'b1; tick(1); start_i = 1'b0;
  endtask

  task automatic drive_frame(input int nlines, input int npix, input int odd_line, input int odd_pix);
    fv_i = 1'b1; tick(2);
    for (int i = 0; i < nlines; i++) begin
      int n;
      n = (i == odd_line) ? odd_pix : npix;
      lv_i = 1'b1; tick(n); lv_i = 1'b0; tick(2);
      if (n != m_exp_pix) m_err = m_err | 1;
      m_pix = m_pix + n;
    end
    if (nlines != m_exp_lines) m_err = m_err | 2;
    tick(1); fv_i = 1'b0; tick(3);
  endtask

  task automatic test_reset();
    reset_i = 1'b1; tick(3); reset_i = 1'b0; tick(1);
    n_cmp++;
    if ({rx_reset_n_o, busy_o, capture_en_o, sof_o, eof_o, done_o, frame_cnt_o, err_flags_o} !== {6'b100000, 8'd0, 4'd0}) begin
      n_fail++; $display("FAIL reset_values: got %b want %b",
        {rx_reset_n_o, busy_o, capture_en_o, sof_o, eof_o, done_o, frame_cnt_o, err_flags_o}, {6'b100000, 12'd0});
    end
  endtask

  task automatic test_single_frame();
    do_start(1, 4, 3);
    tick(20);
    drive_frame(3, 4, -1, 0);
    tick(2);
    n_cmp++; if (n_rstlow - b_rst !== 16) begin n_fail++; $display("FAIL rst_hold: got %0d want 16", n_rstlow - b_rst); end
    n_cmp++; if (rst_fall_cyc !== start_cyc + 1) begin n_fail++; $display("FAIL rst_latency: got %0d want %0d", rst_fall_cyc, start_cyc + 1); end
    n_cmp++; if (n_sof - b_sof !== 1) begin n_fail++; $display("FAIL single_sof: got %0d want 1", n_sof - b_sof); end
    n_cmp++; if (n_eof - b_eof !== 1) begin n_fail++; $display("FAIL single_eof: got %0d want 1", n_eof - b_eof); end
    n_cmp++; if (frame_cnt_o !== 8'd1) begin n_fail++; $display("FAIL single_fcnt: got %0d want 1", frame_cnt_o); end
    n_cmp++; if (err_flags_o !== 4'(m_err)) begin n_fail++; $display("FAIL single_err: got %b want %b", err_flags_o, 4'(m_err)); end
    n_cmp++; if (n_done - b_done !== 1) begin n_fail++; $display("FAIL single_done: got %0d want 1", n_done - b_done); end
    n_cmp++; if (last_done_cyc !== last_eof_cyc + 1) begin n_fail++; $display("FAIL single_done_lag: got %0d want %0d", last_done_cyc, last_eof_cyc + 1); end
    n_cmp++; if (n_cap - b_cap !== 12) begin n_fail++; $display("FAIL single_capture: got %0d want 12", n_cap - b_cap); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy %b want 0", busy_o); end
  endtask

  task automatic test_partial_skip();
    fv_i = 1'b1; tick(1);
    do_start(2, 3, 2);
    for (int i = 0; i < 5; i++) begin lv_i = 1'b1; tick(3); lv_i = 1'b0; tick(2); end
    fv_i = 1'b0; tick(3);
    n_cmp++; if (n_sof - b_sof !== 0) begin n_fail++; $display("FAIL skip_no_sof: got %0d want 0", n_sof - b_sof); end
    drive_frame(2, 3, -1, 0);
    drive_frame(2, 3, -1, 0);
    tick(2);
    n_cmp++; if (frame_cnt_o !== 8'd2) begin n_fail++; $display("FAIL skip_fcnt: got %0d want 2", frame_cnt_o); end
    n_cmp++; if (n_sof - b_sof !== 2) begin n_fail++; $display("FAIL skip_sof: got %0d want 2", n_sof - b_sof); end
    n_cmp++; if (n_done - b_done !== 1) begin n_fail++; $display("FAIL skip_done: got %0d want 1", n_done - b_done); end
    n_cmp++; if (n_cap - b_cap !== m_pix) begin n_fail++; $display("FAIL skip_capture: got %0d want %0d", n_cap - b_cap, m_pix); end
  endtask

  task automatic test_geometry();
    do_start(1, 4, 3);
    tick(20);
    drive_frame(2, 4, 1, 5);
    tick(2);
    n_cmp++; if (err_flags_o !== 4'b0011) begin n_fail++; $display("FAIL geom_flags: got %b want 0011", err_flags_o); end
    n_cmp++; if (err_flags_o !== 4'(m_err)) begin n_fail++; $display("FAIL geom_model: got %b want %b", err_flags_o, 4'(m_err)); end
    n_cmp++; if (n_done - b_done !== 1) begin n_fail++; $display("FAIL geom_done: got %0d want 1", n_done - b_done); end
    tick(5);
    n_cmp++; if (err_flags_o !== 4'b0011) begin n_fail++; $display("FAIL geom_sticky: got %b want 0011", err_flags_o); end
    do_start(1, 4, 3);
    n_cmp++; if (err_flags_o !== 4'b0000) begin n_fail++; $display("FAIL geom_clear: got %b want 0000", err_flags_o); end
    tick(19);
    drive_frame(3, 4, -1, 0);
    tick(2);
    n_cmp++; if (err_flags_o !== 4'b0000) begin n_fail++; $display("FAIL geom_clean: got %b want 0000", err_flags_o); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int ep, el, num, np;
      ep  = $urandom_range(0, 6);
      el  = $urandom_range(1, 4);
      num = $urandom_range(1, 3);
      np  = (ep == 0) ? 2 : ep;
      do_start(num, ep, el);
      tick(20);
      for (int f = 0; f < num; f++) begin
        int nl, odd;
        nl  = ($urandom_range(0, 3) == 0) ? el + 1 : el;
        odd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
        drive_frame(nl, np, odd, np + 1);
      end
      tick(2);
      n_cmp++; if (err_flags_o !== 4'(m_err)) begin n_fail++; $display("FAIL rand%0d_err: got %b want %b", r, err_flags_o, 4'(m_err)); end
      n_cmp++; if (frame_cnt_o !== 8'(num)) begin n_fail++; $display("FAIL rand%0d_fcnt: got %0d want %0d", r, frame_cnt_o, num); end
      n_cmp++; if (n_eof - b_eof !== num) begin n_fail++; $display("FAIL rand%0d_eof: got %0d want %0d", r, n_eof - b_eof, num); end
      n_cmp++; if (n_cap - b_cap !== m_pix) begin n_fail++; $display("FAIL rand%0d_capture: got %0d want %0d", r, n_cap - b_cap, m_pix); end
      n_cmp++; if (last_done_cyc !== last_eof_cyc + 1) begin n_fail++; $display("FAIL rand%0d_done_lag: got %0d want %0d", r, last_done_cyc, last_eof_cyc + 1); end
    end
  endtask

  task automatic test_continuous_abort();
    do_start(0, 2, 1);
    tick(20);
    for (int f = 0; f < 300; f++) drive_frame(1, 2, -1, 0);
    abort_i = 1'b1; tick(1); abort_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL cont_busy: got %b want 0", busy_o); end
    tick(1);
    n_cmp++; if (frame_cnt_o !== 8'(300 % 256)) begin n_fail++; $display("FAIL cont_fcnt: got %0d want %0d", frame_cnt_o, 300 % 256); end
    n_cmp++; if (n_wrap - b_wrap !== 1) begin n_fail++; $display("FAIL cont_wrap: got %0d want 1", n_wrap - b_wrap); end
    n_cmp++; if (n_done - b_done !== 0) begin n_fail++; $display("FAIL cont_no_done: got %0d want 0", n_done - b_done); end
    n_cmp++; if (err_flags_o !== 4'(m_err)) begin n_fail++; $display("FAIL cont_err: got %b want %b", err_flags_o, 4'(m_err)); end
    do_start(1, 4, 3);
    tick(5);
    abort_i = 1'b1; tick(1); abort_i = 1'b0;
    n_cmp++; if ({rx_reset_n_o, busy_o} !== 2'b10) begin n_fail++; $display("FAIL abort_rst: got %b want 10", {rx_reset_n_o, busy_o}); end
  endtask

  task automatic test_lock_loss();
    do_start(1, 4, 3);
    tick(20);
    fv_i = 1'b1; tick(2); lv_i = 1'b1; tick(2);
    pll_lock_i = 1'b0; tick(1);
    n_cmp++; if ({err_flags_o[2], done_o, busy_o} !== 3'b110) begin n_fail++; $display("FAIL lock_loss: got %b want 110", {err_flags_o[2], done_o, busy_o}); end
    lv_i = 1'b0; fv_i = 1'b0; pll_lock_i = 1'b1; tick(3);
    snap();
    start_i = 1'b1; abort_i = 1'b1; tick(1); start_i = 1'b0; abort_i = 1'b0; tick(5);
    n_cmp++; if ({busy_o, err_flags_o} !== 5'b0_0100) begin n_fail++; $display("FAIL start_abort: got %b want 00100", {busy_o, err_flags_o}); end
    n_cmp++; if (n_rstlow - b_rst !== 0) begin n_fail++; $display("FAIL start_abort_rst: got %0d want 0", n_rstlow - b_rst); end
  endtask

  task automatic test_reset_mid();
    do_start(1, 4, 3);
    tick(20);
    fv_i = 1'b1; tick(2); lv_i = 1'b1; tick(3);
    reset_i = 1'b1; tick(1);
    n_cmp++;
    if ({rx_reset_n_o, busy_o, capture_en_o, sof_o, eof_o, done_o, frame_cnt_o, err_flags_o} !== {6'b100000, 8'd0, 4'd0}) begin
      n_fail++; $display("FAIL reset_mid: got %b want %b",
        {rx_reset_n_o, busy_o, capture_en_o, sof_o, eof_o, done_o, frame_cnt_o, err_flags_o}, {6'b100000, 12'd0});
    end
    reset_i = 1'b0; lv_i = 1'b0; fv_i = 1'b0; tick(3);
  endtask

  task automatic test_timeout();
    do_start(1, 4, 3);
`ifdef FRAME_SEQ_TIMEOUT_EN
    tick(116);
    n_cmp++; if (err_flags_o[3] !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b want 0", err_flags_o[3]); end
    tick(1);
    n_cmp++; if ({err_flags_o[3], done_o, busy_o} !== 3'b110) begin n_fail++; $display("FAIL timeout_hit: got %b want 110", {err_flags_o[3], done_o, busy_o}); end
`else
    tick(150);
    n_cmp++; if ({err_flags_o[3], busy_o} !== 2'b01) begin n_fail++; $display("FAIL no_watchdog: got %b want 01", {err_flags_o[3], busy_o}); end
    abort_i = 1'b1; tick(1); abort_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL no_watchdog_abort: got %b want 0", busy_o); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    tick(1);
    test_reset();
    test_single_frame();
    test_partial_skip();
    test_geometry();
    test_random();
    test_continuous_abort();
    test_lock_loss();
    test_reset_mid();
    test_timeout();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mipi_frame_sequencer.md
# mipi_frame_sequencer

Capture sequencer for the MIPI CSI-2 receive chain (D-PHY RX → byte-to-pixel → 10-bit CMOS-style pixel bus). It runs in the pixel clock domain and drives the receive chain's active-low reset. It waits for PLL lock, then discards any partial frame. It captures a programmed number of whole frames and qualifies pixels for the downstream histogram logic. Each line and frame is checked against the expected geometry, and errors are reported as sticky flags.

## Interface
- `PIX_CNT_W`, 12, width of the pixels-per-line counter and `exp_pix_i`
- `LINE_CNT_W`, 12, width of the lines-per-frame counter and `exp_lines_i`
- `FRAME_CNT_W`, 8, width of `num_frames_i` and `frame_cnt_o`
- `RST_HOLD`, 16, number of cycles `rx_reset_n_o` is held low per start (≥2)
- `TIMEOUT`, 2^20, watchdog cycle limit (used only with `FRAME_SEQ_TIMEOUT_EN`)

Ports:
- `clk_pixel_i`  in  1  pixel clock; the only clock
- `reset_i`  in  1  synchronous, active-high reset
- `pll_lock_i`  in  1  pixel PLL lock
- `start_i`  in  1  one-cycle pulse that arms a capture; honoured only in IDLE
- `abort_i`  in  1  one-cycle pulse that stops capture and returns to IDLE
- `num_frames_i`  in  FRAME_CNT_W  frames to capture; 0 = continuous; latched on start
- `exp_pix_i`  in  PIX_CNT_W  expected pixels per line; latched on start
- `exp_lines_i`  in  LINE_CNT_W  expected lines per frame; latched on start
- `fv_i`, `lv_i`  in  1 each  frame valid and line valid from byte-to-pixel
- `rx_reset_n_o`  out  1  active-low reset to the receive chain
- `capture_en_o`  out  1  pixel qualifier for the downstream logic
- `sof_o`, `eof_o`  out  1 each  start-of-frame and end-of-frame pulses, captured frames only
- `busy_o`  out  1  high in any state other than IDLE
- `done_o`  out  1  one-cycle pulse on completion
- `frame_cnt_o`  out  FRAME_CNT_W  count of completed frames
- `err_flags_o`  out  4  sticky flags: [0] line length, [1] line count, [2] lock lost, [3] timeout

## Operation
- Inputs `fv_i` and `lv_i` are registered once into `fv_q` and `lv_q`; edges are detected against these registered copies.

States and transitions:
- **IDLE**: on `start_i`, latch the config inputs, clear `err_flags_o` and `frame_cnt_o`, then go to RST.
- **RST**: `rx_reset_n_o` = 0 for `RST_HOLD` cycles, then go to LOCK.
- **LOCK**: wait for `pll_lock_i` = 1, then go to SYNC.
- **SYNC**: wait for a rising edge of `fv`. A rising edge that arrives while `fv_i` was already high on entry does not count; the frame in progress is skipped. On the edge, pulse `sof_o` and go to CAPT.
- **CAPT**:
  - Pixel counter increments each cycle `lv_i` = 1.
  - On `lv` falling (or `fv` falling with `lv_q` = 1): line counter increments; if pixel count ≠ `exp_pix`, set flag[0]; pixel counter clears.
  - On `fv` falling: if line count ≠ `exp_lines`, set flag[1]; pulse `eof_o`; increment `frame_cnt_o` (wraps); line counter clears.
  - Then: if `num_frames` ≠ 0 and the new count == `num_frames`, go to DONE; otherwise go to GAP.
- **GAP**: on `fv` rising, pulse `sof_o` and go to CAPT.
- **DONE**: pulse `done_o` for one cycle, then go to IDLE.

Boundary conditions:
- `pll_lock_i` = 0 in SYNC, CAPT or GAP: set flag[2], pulse `done_o`, go to IDLE.
- `abort_i` takes priority over every transition except `reset_i`. It goes straight to IDLE, releases `rx_reset_n_o` and does not pulse `done_o`.
- `abort_i` and `start_i` in the same IDLE cycle: stay in IDLE.
- `start_i` while `busy_o` = 1: ignored.
- Pixel and line counters saturate at all-ones; the saturated value still mismatches.
- `exp_pix` or `exp_lines` = 0: every line or frame sets its flag.
- `reset_i` mid-capture: next cycle is IDLE with all outputs at reset values.

## Timing
- Reset values: `rx_reset_n_o` = 1; `busy_o`, `capture_en_o`, `sof_o`, `eof_o`, `done_o` = 0; `frame_cnt_o` = 0; `err_flags_o` = 0.
- All outputs are registered.
- `capture_en_o` = CAPT & `lv_i`, registered, so it lags `lv_i` by exactly 1 cycle. The downstream logic delays `pd` by 1 cycle to align.
- `sof_o` is 2 cycles after the `fv_i` rising sample; `eof_o` is 2 cycles after the `fv_i` falling sample.
- Error flags set in the same cycle as `eof_o` (line count) or 2 cycles after the `lv_i` fall (line length).
- `rx_reset_n_o` goes low the cycle after `start_i` and stays low for exactly `RST_HOLD` cycles.
- `done_o` follows the final `eof_o` by 1 cycle.

## Configuration
- `FRAME_SEQ_TIMEOUT_EN` defined: a watchdog counts cycles spent in LOCK, SYNC or GAP and resets on every state entry. Reaching `TIMEOUT` sets flag[3], pulses `done_o` and goes to IDLE.
- `FRAME_SEQ_TIMEOUT_EN` undefined: no watchdog logic; flag[3] is tied to 0 and those states wait indefinitely.

## Test plan
- **Reset then single frame:** `reset_i`, then `start_i` with num=1, exp_pix=4, exp_lines=3; drive 3 lines of 4 pixels.
  → `rx_reset_n_o` low for 16 cycles; one `sof_o`, one `eof_o`; `frame_cnt_o` = 1; `err_flags_o` = 0; `done_o` pulses; `capture_en_o` high for 12 cycles.
- **Partial-frame skip:** `fv_i` already high at `start_i`; num=2.
  → No `sof_o` until the next `fv` rising edge; exactly 2 frames counted, then `done_o`.
- **Geometry errors:** exp_pix=4; drive one 5-pixel line and 2 lines instead of 3.
  → flags[0] = 1 and [1] = 1, remain set after `done_o`, and clear on the next `start_i`.
- **Continuous mode and abort:** num=0; run 300 frames, then `abort_i`.
  → `frame_cnt_o` wraps 255→0 and ends at 44; no `done_o`; `busy_o` = 0 the next cycle.
- **Lock loss:** `pll_lock_i` drops mid-CAPT.
  → flag[2] = 1, `done_o` pulses, IDLE. Repeat with `start_i` and `abort_i` in the same IDLE cycle → remains in IDLE.
- **Timeout (`FRAME_SEQ_TIMEOUT_EN` defined, `TIMEOUT` = 100):** hold `fv_i` = 0.
  → flag[3] set 100 cycles after SYNC entry; `done_o` pulses.
